// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_done;
   logic [1:0] tx_err;
   logic       tx_err_stb;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, tx_done, tx_err, tx_err_stb
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, tx_done, tx_err, tx_err_stb
   );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a start bit, then
// shifts one command byte out on device clock falls and checks the device ACK.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 10000,
   parameter int unsigned START_CYCLES   = 200,
   parameter int unsigned TIMEOUT_CYCLES = 2000000,
   parameter int unsigned FILTER_LEN     = 4
) (
   input  logic           clk,
   input  logic           clrn,
   ps2_host_tx_if.slave   tx,
   output logic           rx_block,
   input  logic           ps2_clk_in,
   input  logic           ps2_data_in,
   output logic           ps2_clk_oe,
   output logic           ps2_data_oe
);

   localparam int unsigned MAX_A = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
   localparam int unsigned MAX_P = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
   localparam int unsigned CNT_W = $clog2(MAX_P + 1);
   localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
   localparam int unsigned N_W   = 4;

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE, S_ERR
   } state_t;

   // Input conditioning: 2-FF synchronizers, glitch filter on the clock line
   logic [1:0]       clk_s;
   logic [1:0]       dat_s;
   logic [FLT_W-1:0] flt_cnt;
   logic             filt_q;
   logic             filt_d1;
   logic             fall_c;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         clk_s   <= 2'b11;
         dat_s   <= 2'b11;
         flt_cnt <= '0;
         filt_q  <= 1'b1;
         filt_d1 <= 1'b1;
      end else begin
         clk_s   <= {clk_s[0], ps2_clk_in};
         dat_s   <= {dat_s[0], ps2_data_in};
         filt_d1 <= filt_q;
         if (clk_s[1] != filt_q) begin
            if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
               filt_q  <= clk_s[1];
               flt_cnt <= '0;
            end else begin
               flt_cnt <= flt_cnt + FLT_W'(1);
            end
         end else begin
            flt_cnt <= '0;
         end
      end
   end

   assign fall_c = filt_d1 & ~filt_q;

   // FSM and registered outputs
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] tmo_q, tmo_d;
   logic [N_W-1:0]   n_q, n_d;
   logic [7:0]       data_q, data_d;
   logic             par_q, par_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic [1:0]       err_q, err_d;
   logic             stb_q, stb_d;
   logic             rxb_q, rxb_d;
   logic             clk_oe_q, clk_oe_d;
   logic             data_oe_q, data_oe_d;
   logic [1:0]       err_req;
   logic             tmo_hit;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         tmo_q     <= '0;
         n_q       <= '0;
         data_q    <= '0;
         par_q     <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 2'd0;
         stb_q     <= 1'b0;
         rxb_q     <= 1'b0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         n_q       <= n_d;
         data_q    <= data_d;
         par_q     <= par_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         err_q     <= err_d;
         stb_q     <= stb_d;
         rxb_q     <= rxb_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      n_d       = n_q;
      data_d    = data_q;
      par_d     = par_q;
      ready_d   = ready_q;
      done_d    = 1'b0;
      err_d     = 2'd0;
      stb_d     = 1'b0;
      rxb_d     = rxb_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      err_req   = 2'd0;
      tmo_hit   = 1'b0;

      // Inter-fall watchdog; a fall on the terminal cycle still clears it
      if (state_q == S_SEND || state_q == S_ACK || state_q == S_WAIT_IDLE) begin
         if (fall_c) begin
            tmo_d = '0;
         end else if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_hit = 1'b1;
         end else begin
            tmo_d = tmo_q + CNT_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (tx.tx_valid) begin
               data_d    = tx.tx_data;
               par_d     = ~^tx.tx_data;
               state_d   = S_INHIBIT;
               ready_d   = 1'b0;
               rxb_d     = 1'b1;
               clk_oe_d  = 1'b1;
               data_oe_d = 1'b0;
               cnt_d     = '0;
            end
         end
         S_INHIBIT: begin
            if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
               state_d   = S_START;
               cnt_d     = '0;
               data_oe_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_START: begin
            if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
               state_d  = S_SEND;
               cnt_d    = '0;
               clk_oe_d = 1'b0;
               n_d      = '0;
               tmo_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_SEND: begin
            if (fall_c) begin
               n_d = n_q + N_W'(1);
               if (n_q < N_W'(8)) begin
                  data_oe_d = ~data_q[n_q[2:0]];
               end else if (n_q == N_W'(8)) begin
                  data_oe_d = ~par_q;
               end else begin
                  data_oe_d = 1'b0;
                  state_d   = S_ACK;
               end
            end else if (tmo_hit) begin
               err_req = 2'd1;
            end
         end
         S_ACK: begin
            if (fall_c) begin
               n_d = n_q + N_W'(1);
               if (dat_s[1]) begin
                  err_req = 2'd2;
               end else begin
                  state_d = S_WAIT_IDLE;
               end
            end else if (tmo_hit) begin
               err_req = 2'd1;
            end
         end
         S_WAIT_IDLE: begin
            if (filt_q && dat_s[1]) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               ready_d = 1'b1;
               rxb_d   = 1'b0;
            end else if (tmo_hit) begin
               err_req = 2'd1;
            end
         end
         S_ERR: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            rxb_d   = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            rxb_d   = 1'b0;
         end
      endcase

      if (err_req != 2'd0) begin
         state_d   = S_ERR;
         stb_d     = 1'b1;
         err_d     = err_req;
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
      end
   end

   assign tx.tx_ready   = ready_q;
   assign tx.tx_done    = done_q;
   assign tx.tx_err     = err_q;
   assign tx.tx_err_stb = stb_q;
   assign rx_block      = rxb_q;
   assign ps2_clk_oe    = clk_oe_q;
   assign ps2_data_oe   = data_oe_q;

endmodule
